writeback_stage_pipe: RTL and testbench
=======================================

// Module: writeback_stage_pipe
// PURPOSE
//  Parametrised registered writeback stage. Sits between the memory stage and the register-file write port.
//  Selects among 4 result sources and aligns/extends sub-word loads (byte offset from the ALU address).
//  Suppresses writes to x0 and misaligned loads, and supports stall and flush from the hazard unit.
//  Keeps a retired-instruction counter.
// PARAMETERS
//  XLEN        32  datapath width; legal values 32 or 64 (64 adds LD/LWU)
//  REG_ADDR_W  5   register index width
//  CNT_W       64  width of instret counter
// PORTS
//  clk           in   1           clock, rising edge
//  rst           in   1           asynchronous, active-low reset
//  valid_m       in   1           memory-stage instruction valid
//  reg_write_m   in   1           instruction writes rd
//  result_src_m  in   2           0 ALU, 1 load, 2 PC+4, 3 CSR
//  load_funct3_m in   3           load type (RV funct3 encoding)
//  rd_m          in   REG_ADDR_W  destination register
//  alu_result_m  in   XLEN        ALU result / load address
//  read_data_m   in   XLEN        raw aligned memory word
//  pc_plus4_m    in   XLEN        PC+4
//  csr_data_m    in   XLEN        CSR read value
//  stall_w       in   1           hold the stage register
//  flush_w       in   1           kill the stage register
//  valid_w       out  1           registered instruction valid
//  reg_write_w   out  1           register-file write enable
//  rd_w          out  REG_ADDR_W  register-file write index
//  result_w      out  XLEN        register-file write data
//  misalign_w    out  1           registered misaligned-load flag
//  instret       out  CNT_W       retired-instruction count
// BEHAVIOUR
//  - Reset (rst=0, async): all outputs are 0; instret is 0.
//  - Latency: 1 cycle. Inputs are captured at the rising edge; outputs are driven from registers only.
//  - Priority each edge: flush_w > stall_w > capture.
//    - flush_w=1: valid_w=0, reg_write_w=0, misalign_w=0; rd_w and result_w hold; no instret increment.
//    - stall_w=1 (no flush): all registers hold; no instret increment; the write is not repeated
//      (reg_write_w is forced 0 while stalled).
//    - capture: valid_w<=valid_m.
//  - Misalign, with off = alu_result_m[log2(XLEN/8)-1:0]:
//    - true when result_src_m=1 and one of:
//      LH/LHU with off[0]=1; LW/LWU with off[1:0]!=0; LD with off!=0.
//  - reg_write_w <= valid_m & reg_write_m & (rd_m!=0) & !misalign.
//  - misalign_w <= valid_m & misalign.
//  - Load extract when result_src_m=1: field at byte offset off.
//    - LB/LH/LW: sign-extend. LBU/LHU/LWU: zero-extend. LD: full word (XLEN=64 only).
//    - Reserved funct3, or LD/LWU at XLEN=32: read_data_m passes unchanged, no exception.
//  - Result mux: src 0 alu_result_m, 1 extracted load, 2 pc_plus4_m, 3 csr_data_m.
//    result_w is updated on every capture even when the write is suppressed.
//  - instret: +1 on a capture edge with valid_m=1 and !misalign; wraps to 0 at 2^CNT_W-1.
//  - Simultaneous flush and stall: flush wins.
//  - Reset mid-stall clears the stall state immediately.
// STRUCTURE
//  - Package wb_pkg holds:
//    - result-source encodings (SRC_ALU=0, SRC_LOAD=1, SRC_PC4=2, SRC_CSR=3);
//    - load funct3 constants (LB=000, LH=001, LW=010, LD=011, LBU=100, LHU=101, LWU=110).
//  - One combinational sub-module, load_align, computes the extracted value and the misalign flag.
//  - Top level: result mux, stage register, instret counter.
// TESTING
//  1. Reset: hold rst=0 with random inputs -> every output 0; release -> instret stays 0 until the first valid capture.
//  2. LB, addr=0x...3, data=0x80FF_1234 -> result_w=0xFFFF_FF80, reg_write_w=1 one cycle later.
//     LBU, same inputs -> result_w=0x0000_0080.
//  3. LH, addr=0x...1 -> misalign_w=1, reg_write_w=0, instret unchanged.
//     LHU, addr=0x...2, data=0x8001_0000 -> result_w=0x0000_8001.
//  4. rd_m=0, reg_write_m=1, src=ALU -> reg_write_w=0, valid_w=1, instret increments by 1.
//  5. Stall for 3 cycles after a write -> outputs hold, reg_write_w=0 during the stall, instret +0.
//     Then flush with stall=1 -> valid_w=0.
//  6. Preload instret to all-ones via 2^CNT_W-1 retirements (CNT_W=8 build) -> the next retire wraps it to 0.
//     Mux sources 2 and 3 route pc_plus4_m=0x104 and csr_data_m=0xABCD correctly.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared encodings for the writeback stage:
// result-source selects and RV load funct3 values.
package wb_pkg;

  localparam logic [1:0] SRC_ALU  = 2'd0;
  localparam logic [1:0] SRC_LOAD = 2'd1;
  localparam logic [1:0] SRC_PC4  = 2'd2;
  localparam logic [1:0] SRC_CSR  = 2'd3;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LD  = 3'b011;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] LWU = 3'b110;

endpackage

// File: rtl/load_align.sv
// Sub-word load extraction and misalignment detection.
// Purely combinational; byte offset comes from the load address.
module load_align
  import wb_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int OFFW = $clog2(XLEN/8)
) (
  input  logic [2:0]      i_funct3,
  input  logic [OFFW-1:0] i_off,
  input  logic [XLEN-1:0] i_data,
  input  logic            i_is_load,
  output logic [XLEN-1:0] o_value,
  output logic            o_misalign
);

  localparam bit IS64 = (XLEN == 64);

  logic [XLEN-1:0] w_sh;
  logic            w_mis;

  assign w_sh = i_data >> {i_off, 3'b000};

  always_comb begin
    o_value = i_data;
    w_mis   = 1'b0;
    case (i_funct3)
      LB:  o_value = XLEN'($signed(w_sh[7:0]));
      LBU: o_value = XLEN'(w_sh[7:0]);
      LH: begin
        o_value = XLEN'($signed(w_sh[15:0]));
        w_mis   = i_off[0];
      end
      LHU: begin
        o_value = XLEN'(w_sh[15:0]);
        w_mis   = i_off[0];
      end
      LW: begin
        o_value = XLEN'($signed(w_sh[31:0]));
        w_mis   = |i_off[1:0];
      end
      // LD/LWU only exist on RV64; on RV32 they pass data through
      LWU: begin
        if (IS64) begin
          o_value = XLEN'(w_sh[31:0]);
          w_mis   = |i_off[1:0];
        end
      end
      LD: begin
        if (IS64) begin
          o_value = w_sh;
          w_mis   = |i_off;
        end
      end
      default: o_value = i_data;
    endcase
  end

  assign o_misalign = i_is_load & w_mis;

endmodule

// File: rtl/writeback_stage_pipe.sv
// Registered writeback stage: result mux, stage register
// with stall/flush, and retired-instruction counter.
module writeback_stage_pipe
  import wb_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_m,
  input  logic                  reg_write_m,
  input  logic [1:0]            result_src_m,
  input  logic [2:0]            load_funct3_m,
  input  logic [REG_ADDR_W-1:0] rd_m,
  input  logic [XLEN-1:0]       alu_result_m,
  input  logic [XLEN-1:0]       read_data_m,
  input  logic [XLEN-1:0]       pc_plus4_m,
  input  logic [XLEN-1:0]       csr_data_m,
  input  logic                  stall_w,
  input  logic                  flush_w,
  output logic                  valid_w,
  output logic                  reg_write_w,
  output logic [REG_ADDR_W-1:0] rd_w,
  output logic [XLEN-1:0]       result_w,
  output logic                  misalign_w,
  output logic [CNT_W-1:0]      instret
);

  localparam int OFFW = $clog2(XLEN/8);

  logic [XLEN-1:0]       w_load;
  logic                  w_mis;
  logic [XLEN-1:0]       w_result;
  logic                  w_we;

  logic                  r_valid;
  logic                  r_we;
  logic [REG_ADDR_W-1:0] r_rd;
  logic [XLEN-1:0]       r_result;
  logic                  r_mis;
  logic [CNT_W-1:0]      r_instret;

  load_align #(
    .XLEN(XLEN)
  ) u_align (
    .i_funct3  (load_funct3_m),
    .i_off     (alu_result_m[OFFW-1:0]),
    .i_data    (read_data_m),
    .i_is_load (result_src_m == SRC_LOAD),
    .o_value   (w_load),
    .o_misalign(w_mis)
  );

  always_comb begin
    w_result = alu_result_m;
    case (result_src_m)
      SRC_ALU:  w_result = alu_result_m;
      SRC_LOAD: w_result = w_load;
      SRC_PC4:  w_result = pc_plus4_m;
      SRC_CSR:  w_result = csr_data_m;
      default:  w_result = alu_result_m;
    endcase
  end

  assign w_we = valid_m & reg_write_m
              & (rd_m != '0) & ~w_mis;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid   <= 1'b0;
      r_we      <= 1'b0;
      r_rd      <= '0;
      r_result  <= '0;
      r_mis     <= 1'b0;
      r_instret <= '0;
    end else if (flush_w) begin
      r_valid <= 1'b0;
      r_we    <= 1'b0;
      r_mis   <= 1'b0;
    end else if (stall_w) begin
      // a held instruction must not write the regfile twice
      r_we <= 1'b0;
    end else begin
      r_valid  <= valid_m;
      r_we     <= w_we;
      r_rd     <= rd_m;
      r_result <= w_result;
      r_mis    <= valid_m & w_mis;
      if (valid_m && !w_mis)
        r_instret <= r_instret + CNT_W'(1);
    end
  end

  assign valid_w     = r_valid;
  assign reg_write_w = r_we;
  assign rd_w        = r_rd;
  assign result_w    = r_result;
  assign misalign_w  = r_mis;
  assign instret     = r_instret;

endmodule

// File: tb/tb_writeback_stage_pipe.sv
// Scoreboard bench for writeback_stage_pipe (XLEN=32, CNT_W=8):
// driver pushes model outputs, monitor pops and compares.
module tb_writeback_stage_pipe;

  localparam int XLEN = 32;
  localparam int RW   = 5;
  localparam int CW   = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            valid_m, reg_write_m;
  logic [1:0]      result_src_m;
  logic [2:0]      load_funct3_m;
  logic [RW-1:0]   rd_m;
  logic [XLEN-1:0] alu_result_m, read_data_m;
  logic [XLEN-1:0] pc_plus4_m, csr_data_m;
  logic            stall_w, flush_w;
  logic            valid_w, reg_write_w, misalign_w;
  logic [RW-1:0]   rd_w;
  logic [XLEN-1:0] result_w;
  logic [CW-1:0]   instret;

  always #5 clk = ~clk;

  writeback_stage_pipe #(
    .XLEN(XLEN), .REG_ADDR_W(RW), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst),
    .valid_m(valid_m), .reg_write_m(reg_write_m),
    .result_src_m(result_src_m),
    .load_funct3_m(load_funct3_m),
    .rd_m(rd_m), .alu_result_m(alu_result_m),
    .read_data_m(read_data_m),
    .pc_plus4_m(pc_plus4_m), .csr_data_m(csr_data_m),
    .stall_w(stall_w), .flush_w(flush_w),
    .valid_w(valid_w), .reg_write_w(reg_write_w),
    .rd_w(rd_w), .result_w(result_w),
    .misalign_w(misalign_w), .instret(instret)
  );

  typedef struct packed {
    logic          v;
    logic          we;
    logic [RW-1:0] rd;
    logic [31:0]   res;
    logic          mis;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t q[$];
  exp_t m;
  int   total = 0;
  int   bad   = 0;
  bit   mon_en = 1'b0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic exp_t outs();
    exp_t a;
    a.v   = valid_w;
    a.we  = reg_write_w;
    a.rd  = rd_w;
    a.res = result_w;
    a.mis = misalign_w;
    a.cnt = instret;
    return a;
  endfunction

  // Reference: shift the word down by the byte offset, then
  // take the field modulo its size, subtracting for negatives.
  function automatic logic [31:0] ld_ref(input logic [2:0] f3,
                                         input logic [31:0] a,
                                         input logic [31:0] d);
    int unsigned off = 32'(a[1:0]);
    int unsigned sh  = d >> (8 * off);
    int          v;
    case (f3)
      3'd0: begin
        v = int'(sh % 256);
        if (v >= 128) v -= 256;
      end
      3'd1: begin
        v = int'(sh % 65536);
        if (v >= 32768) v -= 65536;
      end
      3'd2: v = int'(sh);
      3'd4: v = int'(sh % 256);
      3'd5: v = int'(sh % 65536);
      default: v = int'(d);
    endcase
    return 32'(v);
  endfunction

  function automatic bit mis_ref(input logic [1:0] src,
                                 input logic [2:0] f3,
                                 input logic [31:0] a);
    if (src != 2'd1) return 1'b0;
    if ((f3 == 3'd1 || f3 == 3'd5) && (a % 2 != 0)) return 1'b1;
    if (f3 == 3'd2 && (a % 4 != 0)) return 1'b1;
    return 1'b0;
  endfunction

  task automatic issue(input logic vm, input logic wm,
                       input logic [1:0] src,
                       input logic [2:0] f3,
                       input logic [RW-1:0] rd,
                       input logic [31:0] alu,
                       input logic [31:0] dat,
                       input logic [31:0] pc4,
                       input logic [31:0] csr,
                       input logic st, input logic fl);
    bit          mis;
    logic [31:0] res;
    @(negedge clk);
    valid_m = vm; reg_write_m = wm;
    result_src_m = src; load_funct3_m = f3; rd_m = rd;
    alu_result_m = alu; read_data_m = dat;
    pc_plus4_m = pc4; csr_data_m = csr;
    stall_w = st; flush_w = fl;
    if (fl) begin
      m.v = 1'b0; m.we = 1'b0; m.mis = 1'b0;
    end else if (st) begin
      m.we = 1'b0;
    end else begin
      mis = mis_ref(src, f3, alu);
      case (src)
        2'd0: res = alu;
        2'd1: res = ld_ref(f3, alu, dat);
        2'd2: res = pc4;
        default: res = csr;
      endcase
      m.v   = vm;
      m.we  = vm && wm && (rd != 0) && !mis;
      m.rd  = rd;
      m.res = res;
      m.mis = vm && mis;
      if (vm && !mis) m.cnt = CW'((int'(m.cnt) + 1) % 256);
    end
    q.push_back(m);
  endtask

  task automatic alu_op(input logic [RW-1:0] rd,
                        input logic [31:0] val);
    issue(1, 1, 2'd0, 3'd0, rd, val, $urandom, $urandom,
          $urandom, 0, 0);
  endtask

  task automatic load(input logic [2:0] f3,
                      input logic [RW-1:0] rd,
                      input logic [31:0] a,
                      input logic [31:0] d);
    issue(1, 1, 2'd1, f3, rd, a, d, $urandom, $urandom, 0, 0);
  endtask

  task automatic probe();
    @(posedge clk);
    #2;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (mon_en && q.size() > 0) begin
        e = q.pop_front();
        chk("wb_outputs", 64'(outs()), 64'(e));
      end
    end
  end

  initial begin : driver
    int guard;
    rst = 1'b0;
    valid_m = 0; reg_write_m = 0; result_src_m = 0;
    load_funct3_m = 0; rd_m = 0; alu_result_m = 0;
    read_data_m = 0; pc_plus4_m = 0; csr_data_m = 0;
    stall_w = 0; flush_w = 0;
    m = '0;

    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      valid_m = 1; reg_write_m = 1;
      result_src_m = 2'($urandom);
      rd_m = 5'($urandom) | 5'd1;
      alu_result_m = $urandom; read_data_m = $urandom;
      pc_plus4_m = $urandom; csr_data_m = $urandom;
      @(posedge clk);
      #1;
      chk("reset_outputs", 64'(outs()), 64'd0);
    end
    #2;
    rst = 1'b1;
    mon_en = 1'b1;

    issue(0, 1, 2'd0, 3'd0, 5'd4, 32'h55, 0, 0, 0, 0, 0);
    issue(0, 1, 2'd2, 3'd0, 5'd5, 32'h66, 0, 0, 0, 0, 0);

    load(3'd0, 5'd10, 32'h1003, 32'h80FF_1234);
    probe();
    chk("lb_result", 64'(result_w), 64'hFFFF_FF80);
    chk("lb_we", 64'(reg_write_w), 64'd1);
    load(3'd4, 5'd11, 32'h1003, 32'h80FF_1234);
    probe();
    chk("lbu_result", 64'(result_w), 64'h0000_0080);

    load(3'd1, 5'd12, 32'h2001, 32'h1234_5678);
    probe();
    chk("lh_mis", 64'(misalign_w), 64'd1);
    chk("lh_mis_we", 64'(reg_write_w), 64'd0);
    chk("lh_mis_cnt", 64'(instret), 64'd2);
    load(3'd5, 5'd13, 32'h2002, 32'h8001_0000);
    probe();
    chk("lhu_result", 64'(result_w), 64'h0000_8001);

    alu_op(5'd0, 32'hDEAD_BEEF);
    probe();
    chk("x0_we", 64'(reg_write_w), 64'd0);
    chk("x0_valid", 64'(valid_w), 64'd1);
    chk("x0_cnt", 64'(instret), 64'd4);

    alu_op(5'd7, 32'h0000_0777);
    for (int i = 0; i < 3; i++) begin
      issue(1, 1, 2'($urandom), 3'($urandom), 5'd9, $urandom,
            $urandom, $urandom, $urandom, 1, 0);
      probe();
      chk("stall_we", 64'(reg_write_w), 64'd0);
      chk("stall_hold", 64'(result_w), 64'h777);
    end
    chk("stall_cnt", 64'(instret), 64'd5);
    issue(1, 1, 2'd0, 3'd0, 5'd9, 32'h1, 0, 0, 0, 1, 1);
    probe();
    chk("flush_valid", 64'(valid_w), 64'd0);

    issue(1, 1, 2'd2, 3'd0, 5'd1, 32'h9, 0, 32'h104, 32'hABCD,
          0, 0);
    probe();
    chk("src_pc4", 64'(result_w), 64'h104);
    issue(1, 1, 2'd3, 3'd0, 5'd1, 32'h9, 0, 32'h104, 32'hABCD,
          0, 0);
    probe();
    chk("src_csr", 64'(result_w), 64'hABCD);

    for (int i = 0; i < 400; i++) begin
      issue($urandom_range(0, 3) != 0, 1'($urandom),
            2'($urandom), 3'($urandom), 5'($urandom),
            $urandom, $urandom, $urandom, $urandom,
            $urandom_range(0, 6) == 0,
            $urandom_range(0, 9) == 0);
    end

    guard = 0;
    while (m.cnt != 8'hFF && guard < 300) begin
      alu_op(5'($urandom), $urandom);
      guard++;
    end
    probe();
    chk("cnt_all_ones", 64'(instret), 64'hFF);
    alu_op(5'd3, 32'h3);
    probe();
    chk("cnt_wrap", 64'(instret), 64'd0);

    mon_en = 1'b0;
    chk("queue_drained", 64'(q.size()), 64'd0);

    alu_op(5'd6, 32'h66);
    issue(1, 1, 2'd0, 3'd0, 5'd8, 32'h88, 0, 0, 0, 1, 0);
    probe();
    rst = 1'b0;
    #1;
    chk("reset_mid_stall", 64'(outs()), 64'd0);
    @(posedge clk);
    #1;
    chk("reset_hold", 64'(outs()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
